// File: rtl/overdrive_ctrl.sv
// Configuration sequencer for the overdrive clipper: accepts threshold/bypass requests,
// ramps the live threshold per audio sample and swaps bypass only while the clipper is open.
module overdrive_ctrl #(
    parameter int DATA_WIDTH     = 24,
    parameter int STEP           = 1024,
    parameter int MIN_THRESH     = 1024,
    parameter int MAX_THRESH     = (2 ** (DATA_WIDTH - 1)) - 1,
    parameter int DEFAULT_THRESH = 100000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         sample_tick,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic signed [DATA_WIDTH-1:0] cfg_threshold,
    input  logic                         cfg_bypass,
    output logic signed [DATA_WIDTH-1:0] threshold_out,
    output logic                         bypass_out,
    output logic                         busy,
    output logic                         done
);

    typedef enum logic [1:0] {
        IDLE,
        RAMP_OPEN,
        SWITCH,
        RAMP
    } state_e;

    localparam logic signed [DATA_WIDTH-1:0] MIN_T  = DATA_WIDTH'(MIN_THRESH);
    localparam logic signed [DATA_WIDTH-1:0] MAX_T  = DATA_WIDTH'(MAX_THRESH);
    localparam logic signed [DATA_WIDTH-1:0] DEF_T  = DATA_WIDTH'(DEFAULT_THRESH);
    localparam logic signed [DATA_WIDTH-1:0] STEP_T = DATA_WIDTH'(STEP);
    localparam logic signed [DATA_WIDTH:0]   STEP_W = (DATA_WIDTH + 1)'(STEP);
    localparam logic signed [DATA_WIDTH:0]   MIN_W  = (DATA_WIDTH + 1)'(MIN_THRESH);
    localparam logic signed [DATA_WIDTH:0]   MAX_W  = (DATA_WIDTH + 1)'(MAX_THRESH);

    state_e                         state_q;
    logic signed [DATA_WIDTH-1:0]   threshold_q;
    logic signed [DATA_WIDTH-1:0]   target_q;
    logic                           bypass_q;
    logic                           bypass_req_q;
    logic                           done_q;

    logic signed [DATA_WIDTH:0]     req_wide;
    logic signed [DATA_WIDTH-1:0]   req_clamped;
    logic signed [DATA_WIDTH-1:0]   goal;
    logic signed [DATA_WIDTH:0]     diff;
    logic                           goal_reached;
    logic signed [DATA_WIDTH-1:0]   thresh_step_d;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves a latch.
    always_comb begin
        req_wide    = (DATA_WIDTH + 1)'(cfg_threshold);
        req_clamped = cfg_threshold;
        if (req_wide < MIN_W) begin
            req_clamped = MIN_T;
        end else if (req_wide > MAX_W) begin
            req_clamped = MAX_T;
        end
    end

    // One extra bit keeps target - threshold exact across the full signed range.
    always_comb begin
        goal          = (state_q == RAMP_OPEN) ? MAX_T : target_q;
        diff          = (DATA_WIDTH + 1)'(goal) - (DATA_WIDTH + 1)'(threshold_q);
        goal_reached  = (diff <= STEP_W) && (diff >= -STEP_W);
        thresh_step_d = goal;
        if (!goal_reached) begin
            thresh_step_d = diff[DATA_WIDTH] ? (threshold_q - STEP_T) : (threshold_q + STEP_T);
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            threshold_q  <= DEF_T;
            target_q     <= DEF_T;
            bypass_q     <= 1'b0;
            bypass_req_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cfg_valid) begin
                        target_q     <= req_clamped;
                        bypass_req_q <= cfg_bypass;
                        if (cfg_bypass != bypass_q) begin
                            state_q <= RAMP_OPEN;
                        end else if (req_clamped != threshold_q) begin
                            state_q <= RAMP;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                RAMP_OPEN: begin
                    if (sample_tick) begin
                        threshold_q <= thresh_step_d;
                        if (goal_reached) begin
                            state_q <= SWITCH;
                        end
                    end
                end
                SWITCH: begin
                    bypass_q <= bypass_req_q;
                    if (target_q == MAX_T) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= RAMP;
                    end
                end
                RAMP: begin
                    if (sample_tick) begin
                        threshold_q <= thresh_step_d;
                        if (goal_reached) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cfg_ready     = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign threshold_out = threshold_q;
    assign bypass_out    = bypass_q;
    assign done          = done_q;

endmodule

// File: tb/tb_overdrive_ctrl.sv
// Self-checking bench for overdrive_ctrl: a default-STEP instance driven from a vector table and
// directed corner sequences, plus a large-STEP instance exercised with randomized requests.
module tb_overdrive_ctrl;

    localparam longint MIN_T  = 1024;
    localparam longint MAX_T  = 8388607;
    localparam longint DEF_T  = 100000;
    localparam longint A_STEP = 1024;
    localparam longint B_STEP = 1048576;

    typedef struct {
        longint req;
        logic   bp;
        int     n_ticks;
        longint exp_thr;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               a_rst, a_tick, a_valid, a_ready, a_cfg_bp, a_bp, a_busy, a_done;
    logic signed [23:0] a_cfg_thr, a_thr;
    logic               b_rst, b_tick, b_valid, b_ready, b_cfg_bp, b_bp, b_busy, b_done;
    logic signed [24:0] b_cfg_thr, b_thr;

    int     total = 0;
    int     bad   = 0;
    longint a_m_thr;
    longint b_m_thr;
    logic   b_m_bp;

    overdrive_ctrl u_dut (
        .clk(clk), .reset(a_rst), .sample_tick(a_tick), .cfg_valid(a_valid), .cfg_ready(a_ready),
        .cfg_threshold(a_cfg_thr), .cfg_bypass(a_cfg_bp), .threshold_out(a_thr),
        .bypass_out(a_bp), .busy(a_busy), .done(a_done)
    );

    // One bit wider so a 9000000 request is representable and exercises the upper clamp.
    overdrive_ctrl #(.DATA_WIDTH(25), .STEP(1048576), .MAX_THRESH(8388607)) u_big (
        .clk(clk), .reset(b_rst), .sample_tick(b_tick), .cfg_valid(b_valid), .cfg_ready(b_ready),
        .cfg_threshold(b_cfg_thr), .cfg_bypass(b_cfg_bp), .threshold_out(b_thr),
        .bypass_out(b_bp), .busy(b_busy), .done(b_done)
    );

    task automatic check(input string name, input logic signed [63:0] got, input logic signed [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    function automatic longint clamp(input longint v);
        if (v < MIN_T) return MIN_T;
        if (v > MAX_T) return MAX_T;
        return v;
    endfunction

    // Threshold after k ticks of a ramp from start toward goal: closed form of the step rule.
    function automatic longint after_ticks(input longint start, input longint goal, input int k, input longint step);
        longint d, reach;
        d     = goal - start;
        reach = longint'(k) * step;
        if (d <= reach && -d <= reach) return goal;
        return (d > 0) ? start + reach : start - reach;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic a_reset(input string name);
        a_rst = 1'b1; a_valid = 1'b0; a_tick = 1'b0;
        cycle();
        cycle();
        a_rst   = 1'b0;
        a_m_thr = DEF_T;
        check({name, "_thr"}, a_thr, DEF_T);
        check({name, "_bp"}, a_bp, 0);
        check({name, "_ready"}, a_ready, 1);
        check({name, "_busy"}, a_busy, 0);
        check({name, "_done"}, a_done, 0);
    endtask

    task automatic b_reset();
        b_rst = 1'b1; b_valid = 1'b0; b_tick = 1'b0;
        cycle();
        cycle();
        b_rst   = 1'b0;
        b_m_thr = DEF_T;
        b_m_bp  = 1'b0;
        check("b_reset_thr", b_thr, DEF_T);
        check("b_reset_bp", b_bp, 0);
        check("b_reset_ready", b_ready, 1);
    endtask

    // Request on the default instance with unchanged bypass; a gap cycle between ticks.
    task automatic a_run(input string name, input longint req, input logic bp, input int n_ticks, input longint exp_final);
        longint start, goal, exp;
        start = a_m_thr;
        goal  = clamp(req);
        check({name, "_ready"}, a_ready, 1);
        a_valid = 1'b1; a_cfg_thr = 24'(req); a_cfg_bp = bp;
        cycle();
        a_valid = 1'b0;
        if (n_ticks == 0) begin
            check({name, "_noop_done"}, a_done, 1);
            check({name, "_noop_thr"}, a_thr, exp_final);
        end else begin
            check({name, "_busy"}, a_busy, 1);
            check({name, "_ready_low"}, a_ready, 0);
            for (int k = 1; k <= n_ticks; k++) begin
                a_tick = 1'b1;
                cycle();
                a_tick = 1'b0;
                exp = after_ticks(start, goal, k, A_STEP);
                check({name, "_tick_thr"}, a_thr, exp);
                check({name, "_tick_done"}, a_done, k == n_ticks);
                if (k < n_ticks) begin
                    cycle();
                    check({name, "_hold_thr"}, a_thr, exp);
                end
            end
            check({name, "_final"}, a_thr, exp_final);
        end
        cycle();
        check({name, "_done_clear"}, a_done, 0);
        check({name, "_idle_ready"}, a_ready, 1);
        a_m_thr = exp_final;
    endtask

    task automatic b_gap(input bit noisy, input string name, input longint hold);
        int n;
        n = noisy ? int'($urandom_range(0, 2)) : 0;
        for (int i = 0; i < n; i++) begin
            b_valid   = 1'($urandom_range(0, 1));
            b_cfg_thr = 25'($urandom);
            b_cfg_bp  = 1'($urandom_range(0, 1));
            cycle();
            b_valid = 1'b0;
        end
        if (n > 0) check({name, "_gap_hold"}, b_thr, hold);
    endtask

    task automatic big_txn(input string name, input longint req, input logic bp, input bit noisy,
                           output int n_open, output int n_ramp);
        longint goal, start, exp;
        int     k;
        goal   = clamp(req);
        n_open = 0;
        n_ramp = 0;
        check({name, "_ready"}, b_ready, 1);
        b_valid = 1'b1; b_cfg_thr = 25'(req); b_cfg_bp = bp;
        b_tick  = noisy ? 1'($urandom_range(0, 1)) : 1'b1;
        cycle();
        b_valid = 1'b0; b_tick = 1'b0;
        check({name, "_accept_hold"}, b_thr, b_m_thr);
        if (bp != b_m_bp) begin
            start = b_m_thr;
            exp   = start;
            k     = 0;
            do begin
                b_gap(noisy, name, exp);
                b_tick = 1'b1;
                cycle();
                b_tick = 1'b0;
                k++;
                exp = after_ticks(start, MAX_T, k, B_STEP);
                check({name, "_open_thr"}, b_thr, exp);
                check({name, "_open_bp"}, b_bp, b_m_bp);
                check({name, "_open_done"}, b_done, 0);
            end while (exp != MAX_T && k < 64);
            n_open  = k;
            b_m_thr = MAX_T;
            b_tick  = noisy ? 1'($urandom_range(0, 1)) : 1'b1;
            cycle();
            b_tick = 1'b0;
            b_m_bp = bp;
            check({name, "_switch_bp"}, b_bp, bp);
            check({name, "_switch_thr"}, b_thr, MAX_T);
            check({name, "_switch_done"}, b_done, goal == MAX_T);
        end else begin
            check({name, "_noop_done"}, b_done, goal == b_m_thr);
        end
        if (goal != b_m_thr) begin
            start = b_m_thr;
            exp   = start;
            k     = 0;
            do begin
                b_gap(noisy, name, exp);
                b_tick = 1'b1;
                cycle();
                b_tick = 1'b0;
                k++;
                exp = after_ticks(start, goal, k, B_STEP);
                check({name, "_ramp_thr"}, b_thr, exp);
                check({name, "_ramp_bp"}, b_bp, b_m_bp);
                check({name, "_ramp_done"}, b_done, exp == goal);
            end while (exp != goal && k < 64);
            n_ramp  = k;
            b_m_thr = goal;
        end
        cycle();
        check({name, "_done_clear"}, b_done, 0);
        check({name, "_idle_ready"}, b_ready, 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, expected test end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t   vecs[$];
        int     no, nr;
        int     mode;
        longint req;
        logic signed [24:0] r;

        a_rst = 1'b1; a_tick = 1'b0; a_valid = 1'b0; a_cfg_thr = '0; a_cfg_bp = 1'b0;
        b_rst = 1'b1; b_tick = 1'b0; b_valid = 1'b0; b_cfg_thr = '0; b_cfg_bp = 1'b0;

        vecs.push_back('{104096,     1'b0, 4,   104096});
        vecs.push_back('{103596,     1'b0, 1,   103596});
        vecs.push_back('{103596,     1'b0, 0,   103596});
        vecs.push_back('{-5,         1'b0, 101, 1024});
        vecs.push_back('{1024,       1'b0, 0,   1024});
        vecs.push_back('{2000,       1'b0, 1,   2000});
        vecs.push_back('{0,          1'b0, 1,   1024});
        vecs.push_back('{5000,       1'b0, 4,   5000});
        vecs.push_back('{-8388608,   1'b0, 4,   1024});

        a_reset("reset");
        foreach (vecs[i]) a_run($sformatf("vec%0d", i), vecs[i].req, vecs[i].bp, vecs[i].n_ticks, vecs[i].exp_thr);

        a_reset("reset_snap");
        a_run("snap", 100500, 1'b0, 1, 100500);
        a_run("repeat", 100500, 1'b0, 0, 100500);

        // Tick coincident with accept must not step; a request while busy is dropped.
        a_reset("reset_busy");
        a_valid = 1'b1; a_cfg_thr = 24'(104096); a_cfg_bp = 1'b0; a_tick = 1'b1;
        cycle();
        a_valid = 1'b0; a_tick = 1'b0;
        check("accept_tick_nostep", a_thr, 100000);
        a_tick = 1'b1;
        cycle();
        a_tick = 1'b0;
        check("busy_tick1", a_thr, 101024);
        a_valid = 1'b1; a_cfg_thr = 24'(50000); a_cfg_bp = 1'b1;
        cycle();
        a_valid = 1'b0;
        check("busy_ready_low", a_ready, 0);
        check("busy_ignored_thr", a_thr, 101024);
        for (int k = 2; k <= 4; k++) begin
            a_tick = 1'b1;
            cycle();
            a_tick = 1'b0;
            check("busy_tick_thr", a_thr, after_ticks(100000, 104096, k, A_STEP));
        end
        check("busy_final_done", a_done, 1);
        check("busy_final_bp", a_bp, 0);
        cycle();
        check("busy_done_clear", a_done, 0);

        // Reset mid-ramp wins over a coincident tick and suppresses done.
        a_reset("reset_mid");
        a_valid = 1'b1; a_cfg_thr = 24'(104096); a_cfg_bp = 1'b0;
        cycle();
        a_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            a_tick = 1'b1;
            cycle();
            a_tick = 1'b0;
        end
        check("mid_thr", a_thr, 102048);
        a_rst = 1'b1; a_tick = 1'b1;
        cycle();
        a_rst = 1'b0;
        check("mid_reset_thr", a_thr, DEF_T);
        check("mid_reset_busy", a_busy, 0);
        check("mid_reset_ready", a_ready, 1);
        check("mid_reset_done", a_done, 0);
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("idle_tick_thr", a_thr, DEF_T);
            check("idle_tick_done", a_done, 0);
        end
        a_tick = 1'b0;

        b_reset();
        big_txn("bypass_on", 100000, 1'b1, 1'b0, no, nr);
        check("bypass_on_open_ticks", no, 8);
        check("bypass_on_ramp_ticks", nr, 8);
        check("bypass_on_thr", b_thr, 100000);
        big_txn("clamp_high", 9000000, 1'b1, 1'b0, no, nr);
        check("clamp_high_ticks", nr, 8);
        check("clamp_high_thr", b_thr, MAX_T);
        big_txn("open_at_max", MAX_T, 1'b0, 1'b0, no, nr);
        check("open_at_max_ticks", no, 1);
        check("open_at_max_ramp", nr, 0);
        big_txn("clamp_low", -5, 1'b0, 1'b0, no, nr);
        check("clamp_low_thr", b_thr, MIN_T);

        for (int t = 0; t < 40; t++) begin
            mode = int'($urandom_range(0, 3));
            case (mode)
                0: begin r = 25'($urandom); req = r; end
                1: req = b_m_thr + longint'($urandom_range(0, 6000000)) - 3000000;
                2: req = MAX_T + longint'($urandom_range(0, 100));
                default: req = longint'($urandom_range(0, 3000)) - 1500;
            endcase
            big_txn($sformatf("rnd%0d", t), req, 1'($urandom_range(0, 1)), 1'b1, no, nr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
